// File: rtl/uart_tx_mmio_if.sv
// uart_tx_mmio_if: CPU data-bus view of the UART window.
// Store address/data/strobe in, combinational read data out.
interface uart_tx_mmio_if;
    logic [31:0] address;
    logic [31:0] data_in;
    logic        write_enable;
    logic [31:0] data_out;

    modport master (
        output address,
        output data_in,
        output write_enable,
        input  data_out
    );

    modport slave (
        input  address,
        input  data_in,
        input  write_enable,
        output data_out
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter.
// TXDATA pushes into a byte FIFO; STATUS is polled over the same bus.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_mmio_if.slave bus,
    output logic          tx,
    output logic          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic hit, sel_data, sel_stat;
    logic wr_data, wr_stat;
    logic full, empty;
    logic push, pop;
    logic baud_last;
    logic [4:0]  cnt5;
    logic [31:0] status;
    logic        unused_bits;

    assign hit      = (bus.address[31:3] == BASE_ADDR[31:3]);
    assign sel_data = hit && (bus.address[2:0] == 3'd0);
    assign sel_stat = hit && (bus.address[2:0] == 3'd4);
    assign wr_data  = bus.write_enable && sel_data;
    assign wr_stat  = bus.write_enable && sel_stat;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign push      = wr_data && !full;
    assign baud_last = (baud_q == BAUD_LAST);

    assign busy = !empty || (state_q != S_IDLE);
    assign tx   = tx_q;

    assign unused_bits = ^bus.data_in[31:8];

    // Read mux: STATUS is the only readable register.
    always_comb begin
        cnt5          = 5'(count_q);
        status        = '0;
        status[0]     = busy;
        status[1]     = full;
        status[2]     = empty;
        status[3]     = ovf_q;
        status[8:4]   = cnt5;
        bus.data_out  = sel_stat ? status : 32'h0;
    end

    // FIFO pointer/count/overflow next state; full check uses pre-edge count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (wr_data && full) begin
            ovf_d = 1'b1;
        end else if (wr_stat && bus.data_in[3]) begin
            ovf_d = 1'b0;
        end
    end

    // Byte storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.data_in[7:0];
        end
    end

    // FIFO bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Frame sequencer: popping in STOP chains frames without an idle gap.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        bit_d   = '0;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Line level derived from the upcoming state so tx is a clean register.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Sequencer registers; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the CPU data bus, in parallel with `ram`. It consumes the memory stage's store traffic (address, write data, write enable) when the address hits its window. Accepted bytes are queued in a small FIFO and serialised 8N1, LSB first, on `tx`. A status register is readable over the same bus, so firmware can poll before writing.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_1000: window base; bits [2:0] must be 0.
- `CLKS_PER_BIT`, 16: clock cycles per UART bit; must be ≥ 2.
- `FIFO_DEPTH`, 8: byte FIFO depth; power of two, 2–16.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high. Clears all state immediately.
- `address`, input, 32: bus address from the memory stage.
- `data_in`, input, 32: store data.
- `write_enable`, input, 1: store strobe, sampled on the rising edge.
- `data_out`, output, 32: combinational read data for `address`.
- `tx`, output, 1: serial line, registered, idles high.
- `busy`, output, 1: high when the FIFO is non-empty or the FSM is not in IDLE.

## Operation
Address decode:
- A hit requires `address[31:3] == BASE_ADDR[31:3]`.
- Offset 0 is TXDATA; offset 4 is STATUS. Any other offset, or no hit, reads 0 and ignores writes.

TXDATA:
- A write pushes `data_in[7:0]`; upper bits are ignored. Reads return 0.
- If the FIFO is full (count sampled before the edge), the byte is dropped and sticky OVF is set. This holds even if a pop happens on the same edge.

STATUS read, all other bits 0:
- bit0 = busy.
- bit1 = FIFO full.
- bit2 = FIFO empty.
- bit3 = OVF.
- bits[8:4] = FIFO count.

STATUS write: `data_in[3]`=1 clears OVF. All other bits are ignored.

FIFO:
- Circular buffer with read/write pointers of width log2(FIFO_DEPTH), wrapping modulo depth.
- A separate count of width log2(FIFO_DEPTH)+1.
- A simultaneous push (not full) and pop leaves the count unchanged.
- A pop is never issued while the FIFO is empty.

TX state machine:
- IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register, clear the bit counter and baud counter, and go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: `tx`=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After 8 bits go to STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. On the final cycle, if the FIFO is non-empty, pop and go directly to START, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
- The baud counter counts 0..CLKS_PER_BIT-1 and wraps. The bit counter has 3 bits.

## Timing
- Reset values: `tx`=1, `busy`=0, FSM=IDLE, FIFO empty, OVF=0, all counters 0. `data_out` at STATUS reads 0x0000_0004.
- A write to an empty FIFO in IDLE, sampled at edge E:
  - count=1 after E;
  - the pop occurs at E+1, and `tx` falls after E+1;
  - STATUS empty reads 1 again after E+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles.
- `busy` rises after E and falls one cycle after the last STOP cycle when no data is queued.
- `data_out` has zero-cycle latency. It reflects the state registered at the most recent edge.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronously), queued bytes are discarded, and no partial frame resumes after release.
- FIFO full: count==FIFO_DEPTH. A push at full and a pop on the same edge gives count FIFO_DEPTH-1, with OVF set.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=8.
- Reset release, read STATUS → 0x0000_0004; `tx`=1; `busy`=0.
- Write 0x55 to BASE+0 → `tx` bit sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles, 40 cycles total, starting one cycle after the write edge. `busy` falls at cycle 41.
- Write 0xA3, 0x0F on consecutive cycles → two contiguous 40-cycle frames with no idle cycle between them; data LSB-first 1,1,0,0,0,1,0,1 then 1,1,1,1,0,0,0,0.
- Write 10 bytes back-to-back → first byte popped at cycle 2, remaining bytes queue, and the last write is dropped: count peaks at 8 and OVF=1. STATUS then reads 0x0000_008B, i.e. busy=1, full=1, OVF=1, count=8. Write STATUS with bit3=1 → OVF=0.
- Write 0x12 to BASE+8, and write 0x12 to BASE_ADDR+32'h10 → no frame on `tx`, FIFO stays empty, both addresses read 0.
- Assert reset 13 cycles into a frame → `tx`=1 within the same cycle (no clock edge). After release: STATUS=0x0000_0004 and no further frame on `tx`.
